// File: rtl/axi_wr_slave_engine_if.sv
// AXI4 write-channel bundle (AW, W, B) between a master and axi_wr_slave_engine.
// Handshake rule on every channel: a transfer happens on the rising edge where valid && ready;
// valid never waits on ready, and payload is held stable while valid=1 and ready=0.
interface axi_wr_slave_engine_if #(
  parameter int IDW = 4,
  parameter int AW  = 32,
  parameter int DW  = 64
);
  logic [IDW-1:0]  s_awid;
  logic [AW-1:0]   s_awaddr;
  logic [7:0]      s_awlen;
  logic [2:0]      s_awsize;
  logic [1:0]      s_awburst;
  logic            s_awvalid;
  logic            s_awready;

  logic [DW-1:0]   s_wdata;
  logic [DW/8-1:0] s_wstrb;
  logic            s_wlast;
  logic            s_wvalid;
  logic            s_wready;

  logic [IDW-1:0]  s_bid;
  logic [1:0]      s_bresp;
  logic            s_bvalid;
  logic            s_bready;

  modport slave (
    input  s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
    output s_awready,
    input  s_wdata, s_wstrb, s_wlast, s_wvalid,
    output s_wready,
    output s_bid, s_bresp, s_bvalid,
    input  s_bready
  );

  modport master (
    output s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
    input  s_awready,
    output s_wdata, s_wstrb, s_wlast, s_wvalid,
    input  s_wready,
    input  s_bid, s_bresp, s_bvalid,
    output s_bready
  );
endinterface

// File: rtl/axi_wr_slave_engine.sv
// AXI4 write slave: queues AW requests, walks W beats against the head request onto a
// byte-strobed memory write port, and returns in-order B responses with SLVERR on bad bursts.
module axi_wr_slave_engine #(
  parameter int IDW     = 4,
  parameter int AW      = 32,
  parameter int DW      = 64,
  parameter int MAX_OUT = 4
) (
  input  logic                     axi_aclk,
  input  logic                     rst,
  axi_wr_slave_engine_if.slave     axi,
  output logic                     mem_we,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  output logic [DW/8-1:0]          mem_wstrb,
  output logic [$clog2(MAX_OUT):0] outstanding,
  output logic                     dbg_w_state
);
  localparam int PW = $clog2(MAX_OUT);
  localparam int CW = PW + 1;
  localparam int SW = DW / 8;
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUT);
  localparam logic [2:0]    MAX_SIZE = 3'($clog2(SW));

  typedef enum logic {W_FIRST, W_NEXT} w_state_e;

  // AW request queue
  logic [IDW-1:0] aq_id_q    [MAX_OUT];
  logic [AW-1:0]  aq_addr_q  [MAX_OUT];
  logic [7:0]     aq_len_q   [MAX_OUT];
  logic [2:0]     aq_size_q  [MAX_OUT];
  logic [1:0]     aq_burst_q [MAX_OUT];
  logic [PW-1:0]  aq_wr_q, aq_rd_q;
  logic [CW-1:0]  aq_cnt_q;

  // B response queue
  logic [IDW-1:0] bq_id_q   [MAX_OUT];
  logic [1:0]     bq_resp_q [MAX_OUT];
  logic [PW-1:0]  bq_wr_q, bq_rd_q;
  logic [CW-1:0]  bq_cnt_q;

  logic [CW-1:0]  out_q;
  w_state_e       w_state_q, w_state_d;
  logic [7:0]     beat_cnt_q, beat_cnt_d;
  logic [AW-1:0]  cur_addr_q, cur_addr_d;
  logic           err_q, err_d;

  logic           mem_we_q;
  logic [AW-1:0]  mem_addr_q;
  logic [DW-1:0]  mem_wdata_q;
  logic [SW-1:0]  mem_wstrb_q;

  logic aw_fire, w_fire, b_fire;
  logic [IDW-1:0] h_id;
  logic [AW-1:0]  h_addr;
  logic [7:0]     h_len;
  logic [2:0]     h_size;
  logic [1:0]     h_burst;
  logic           cfg_err, last_beat, beat_err, wr_beat, burst_done;
  logic [AW-1:0]  beat_addr;

  assign axi.s_awready = (out_q < MAX_CNT);
  assign axi.s_wready  = (aq_cnt_q != '0);
  assign axi.s_bvalid  = (bq_cnt_q != '0);
  assign axi.s_bid     = axi.s_bvalid ? bq_id_q[bq_rd_q]   : '0;
  assign axi.s_bresp   = axi.s_bvalid ? bq_resp_q[bq_rd_q] : 2'b00;

  assign aw_fire = axi.s_awvalid && axi.s_awready;
  assign w_fire  = axi.s_wvalid  && axi.s_wready;
  assign b_fire  = axi.s_bvalid  && axi.s_bready;

  assign h_id    = aq_id_q[aq_rd_q];
  assign h_addr  = aq_addr_q[aq_rd_q];
  assign h_len   = aq_len_q[aq_rd_q];
  assign h_size  = aq_size_q[aq_rd_q];
  assign h_burst = aq_burst_q[aq_rd_q];

  // WRAP and reserved bursts, and beats wider than the bus, are rejected for the whole burst.
  assign cfg_err    = h_burst[1] || (h_size > MAX_SIZE);
  assign burst_done = w_fire && last_beat;

  always_comb begin
    w_state_d  = w_state_q;
    beat_cnt_d = beat_cnt_q;
    cur_addr_d = cur_addr_q;
    err_d      = err_q;
    beat_addr  = cur_addr_q;
    beat_err   = err_q;
    wr_beat    = 1'b0;
    last_beat  = (beat_cnt_q == h_len);
    if (w_state_q == W_FIRST) begin
      beat_addr = h_addr;
      beat_err  = cfg_err;
    end
    if (axi.s_wlast != last_beat) beat_err = 1'b1;
    if (w_fire) begin
      wr_beat    = !beat_err;
      cur_addr_d = (h_burst == 2'b01) ? beat_addr + (AW'(1) << h_size) : beat_addr;
      if (last_beat) begin
        w_state_d  = W_FIRST;
        beat_cnt_d = '0;
        err_d      = 1'b0;
      end else begin
        w_state_d  = W_NEXT;
        beat_cnt_d = beat_cnt_q + 8'd1;
        err_d      = beat_err;
      end
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (rst) begin
      aq_wr_q     <= '0;
      aq_rd_q     <= '0;
      aq_cnt_q    <= '0;
      bq_wr_q     <= '0;
      bq_rd_q     <= '0;
      bq_cnt_q    <= '0;
      out_q       <= '0;
      w_state_q   <= W_FIRST;
      beat_cnt_q  <= '0;
      cur_addr_q  <= '0;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      w_state_q  <= w_state_d;
      beat_cnt_q <= beat_cnt_d;
      cur_addr_q <= cur_addr_d;
      err_q      <= err_d;
      if (aw_fire)    aq_wr_q <= aq_wr_q + 1'b1;
      if (burst_done) aq_rd_q <= aq_rd_q + 1'b1;
      case ({aw_fire, burst_done})
        2'b10:   aq_cnt_q <= aq_cnt_q + CW'(1);
        2'b01:   aq_cnt_q <= aq_cnt_q - CW'(1);
        default: aq_cnt_q <= aq_cnt_q;
      endcase
      if (burst_done) bq_wr_q <= bq_wr_q + 1'b1;
      if (b_fire)     bq_rd_q <= bq_rd_q + 1'b1;
      case ({burst_done, b_fire})
        2'b10:   bq_cnt_q <= bq_cnt_q + CW'(1);
        2'b01:   bq_cnt_q <= bq_cnt_q - CW'(1);
        default: bq_cnt_q <= bq_cnt_q;
      endcase
      case ({aw_fire, b_fire})
        2'b10:   out_q <= out_q + CW'(1);
        2'b01:   out_q <= out_q - CW'(1);
        default: out_q <= out_q;
      endcase
      mem_we_q <= wr_beat;
      if (wr_beat) begin
        mem_addr_q  <= beat_addr;
        mem_wdata_q <= axi.s_wdata;
        mem_wstrb_q <= axi.s_wstrb;
      end
    end
  end

  // Queue storage needs no reset: occupancy counters gate every read.
  always_ff @(posedge axi_aclk) begin
    if (aw_fire) begin
      aq_id_q[aq_wr_q]    <= axi.s_awid;
      aq_addr_q[aq_wr_q]  <= axi.s_awaddr;
      aq_len_q[aq_wr_q]   <= axi.s_awlen;
      aq_size_q[aq_wr_q]  <= axi.s_awsize;
      aq_burst_q[aq_wr_q] <= axi.s_awburst;
    end
    if (burst_done) begin
      bq_id_q[bq_wr_q]   <= h_id;
      bq_resp_q[bq_wr_q] <= beat_err ? 2'b10 : 2'b00;
    end
  end

  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_wstrb   = mem_wstrb_q;
  assign outstanding = out_q;
  assign dbg_w_state = w_state_q;
endmodule

// File: tb/tb_axi_wr_slave_engine.sv
// Bench for axi_wr_slave_engine: directed burst table, fill/drain, mid-burst reset and random traffic,
// all scored against a transaction-level model of expected memory writes and B responses.
module tb_axi_wr_slave_engine;
  localparam int IDW = 4, AW = 32, DW = 64, SW = 8, MAX_OUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_wr_slave_engine_if #(.IDW(IDW), .AW(AW), .DW(DW)) axi ();
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_wstrb;
  logic [2:0]    outstanding;
  logic          dbg_w_state;

  axi_wr_slave_engine #(.IDW(IDW), .AW(AW), .DW(DW), .MAX_OUT(MAX_OUT)) dut (
    .axi_aclk    (clk),
    .rst         (rst),
    .axi         (axi),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .outstanding (outstanding),
    .dbg_w_state (dbg_w_state)
  );

  typedef struct {
    logic [IDW-1:0] id;
    logic [AW-1:0]  addr;
    logic [7:0]     len;
    logic [2:0]     size;
    logic [1:0]     burst;
    int             wl;
    logic [31:0]    seed;
  } txn_t;

  typedef struct {
    txn_t       t;
    int         exp_writes;
    logic [1:0] exp_resp;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [AW+DW+SW-1:0] exp_q[$];
  logic [IDW+1:0]      exp_b_q[$];
  int                  wr_count = 0;
  logic [IDW-1:0]      last_bid = '0;
  logic [1:0]          last_bresp = '0;
  logic                rand_bready = 1'b0;
  logic                bready_man = 1'b1;
  logic                rand_gaps = 1'b0;
  vec_t                vecs[$];
  logic [AW+DW+SW-1:0] mon_e;
  logic [IDW+1:0]      mon_b;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(logic [31:0] seed, int k);
    return {seed, seed ^ (32'(k) * 32'h9E3779B9)};
  endfunction

  function automatic logic [SW-1:0] beat_strb(logic [31:0] seed, int k);
    return seed[7:0] ^ 8'(k);
  endfunction

  function automatic logic wl_of(txn_t t, int k);
    return (t.wl < 0) ? (k == int'(t.len)) : (k == t.wl);
  endfunction

  function automatic txn_t mk(logic [IDW-1:0] id, logic [AW-1:0] addr, logic [7:0] len,
                              logic [2:0] size, logic [1:0] burst, int wl);
    txn_t t;
    t.id = id; t.addr = addr; t.len = len; t.size = size; t.burst = burst; t.wl = wl;
    t.seed = $urandom;
    return t;
  endfunction

  function automatic void add_vec(txn_t t, int nw, logic [1:0] resp);
    vec_t v;
    v.t = t; v.exp_writes = nw; v.exp_resp = resp;
    vecs.push_back(v);
  endfunction

  // Reference: once anything about the burst is wrong, that beat and everything after it is dropped.
  function automatic void push_model(txn_t t);
    logic bad;
    logic [AW-1:0] a;
    bad = (t.burst > 2'b01) || (t.size > 3'd3);
    for (int k = 0; k <= int'(t.len); k++) begin
      if (wl_of(t, k) != (k == int'(t.len))) bad = 1'b1;
      a = (t.burst == 2'b00) ? t.addr : t.addr + 32'(k) * (32'd1 << t.size);
      if (!bad) exp_q.push_back({a, beat_data(t.seed, k), beat_strb(t.seed, k)});
    end
    exp_b_q.push_back({t.id, bad ? 2'b10 : 2'b00});
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        wr_count++;
        if (exp_q.size() == 0) check("mem_unexpected", {mem_addr, mem_wdata}, 0);
        else begin
          mon_e = exp_q.pop_front();
          check("mem_addr", mem_addr, mon_e[AW+DW+SW-1:DW+SW]);
          check("mem_wdata", mem_wdata, mon_e[DW+SW-1:SW]);
          check("mem_wstrb", mem_wstrb, mon_e[SW-1:0]);
        end
      end
      if (axi.s_bvalid && axi.s_bready) begin
        last_bid   = axi.s_bid;
        last_bresp = axi.s_bresp;
        if (exp_b_q.size() == 0) check("b_unexpected", {axi.s_bid, axi.s_bresp}, 0);
        else begin
          mon_b = exp_b_q.pop_front();
          check("bid", axi.s_bid, mon_b[IDW+1:2]);
          check("bresp", axi.s_bresp, mon_b[1:0]);
        end
      end
    end
  end

  always @(posedge clk) begin
    #2;
    axi.s_bready = rand_bready ? 1'($urandom_range(0, 1)) : bready_man;
  end

  task automatic aw_send(input txn_t t);
    int n;
    axi.s_awid = t.id; axi.s_awaddr = t.addr; axi.s_awlen = t.len;
    axi.s_awsize = t.size; axi.s_awburst = t.burst; axi.s_awvalid = 1'b1;
    n = 0;
    while (!axi.s_awready && n < 100) begin @(posedge clk); #1; n++; end
    check("aw_timeout", 128'(n >= 100), 0);
    @(posedge clk); #1;
    axi.s_awvalid = 1'b0;
    check("wready_after_aw", axi.s_wready, 1);
  endtask

  task automatic w_send(input txn_t t, output int stalls);
    int n;
    stalls = 0;
    for (int k = 0; k <= int'(t.len); k++) begin
      if (rand_gaps && $urandom_range(0, 3) == 0) begin
        axi.s_wvalid = 1'b0; @(posedge clk); #1;
      end
      axi.s_wvalid = 1'b1; axi.s_wdata = beat_data(t.seed, k);
      axi.s_wstrb = beat_strb(t.seed, k); axi.s_wlast = wl_of(t, k);
      n = 0;
      while (!axi.s_wready && n < 100) begin @(posedge clk); #1; n++; stalls++; end
      check("w_timeout", 128'(n >= 100), 0);
      @(posedge clk); #1;
    end
    axi.s_wvalid = 1'b0; axi.s_wlast = 1'b0;
    check("bvalid_after_last", axi.s_bvalid, 1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_b_q.size() != 0) && n < 400) begin @(posedge clk); #1; n++; end
    check("drain_timeout", 128'(n >= 400), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: run exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    txn_t t;
    txn_t ft[4];
    int   st, tot, wr0;
    axi.s_awid = '0; axi.s_awaddr = '0; axi.s_awlen = '0; axi.s_awsize = '0; axi.s_awburst = '0;
    axi.s_awvalid = 1'b0; axi.s_wdata = '0; axi.s_wstrb = '0; axi.s_wlast = 1'b0; axi.s_wvalid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", axi.s_awready, 1);
    check("rst_wready", axi.s_wready, 0);
    check("rst_bvalid", axi.s_bvalid, 0);
    check("rst_bid_bresp", {axi.s_bid, axi.s_bresp}, 0);
    check("rst_mem", {mem_we, mem_addr, mem_wdata, mem_wstrb}, 0);
    check("rst_outstanding", outstanding, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    add_vec(mk(4'd3, 32'h100, 8'd3, 3'd3, 2'b01, -1), 4, 2'b00);
    add_vec(mk(4'd1, 32'h40, 8'd2, 3'd2, 2'b00, -1), 3, 2'b00);
    add_vec(mk(4'd2, 32'h80, 8'd3, 3'd3, 2'b01, 1), 1, 2'b10);
    add_vec(mk(4'd5, 32'h0, 8'd1, 3'd3, 2'b10, -1), 0, 2'b10);
    add_vec(mk(4'd5, 32'h0, 8'd1, 3'd4, 2'b01, -1), 0, 2'b10);
    add_vec(mk(4'd6, 32'h0, 8'd0, 3'd3, 2'b11, -1), 0, 2'b10);
    add_vec(mk(4'd7, 32'hFFFF_FFF8, 8'd1, 3'd3, 2'b01, -1), 2, 2'b00);
    add_vec(mk(4'd0, 32'h13, 8'd0, 3'd0, 2'b01, -1), 1, 2'b00);
    add_vec(mk(4'd4, 32'h200, 8'd2, 3'd3, 2'b01, 5), 2, 2'b10);

    foreach (vecs[i]) begin
      wr0 = wr_count;
      push_model(vecs[i].t);
      aw_send(vecs[i].t);
      w_send(vecs[i].t, st);
      wait_drain();
      check($sformatf("vec%0d_nwrites", i), 128'(wr_count - wr0), 128'(vecs[i].exp_writes));
      check($sformatf("vec%0d_bresp", i), last_bresp, vecs[i].exp_resp);
      check($sformatf("vec%0d_bid", i), last_bid, vecs[i].t.id);
    end

    // Fill to the outstanding limit with B held off, then drain in order.
    bready_man = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ft[i] = mk(4'(9 + i), 32'h300 + 32'(i * 8), 8'd0, 3'd3, 2'b01, -1);
      push_model(ft[i]);
      aw_send(ft[i]);
    end
    check("fill_awready", axi.s_awready, 0);
    check("fill_outstanding", outstanding, 4);
    tot = 0;
    for (int i = 0; i < 4; i++) begin
      w_send(ft[i], st);
      tot += st;
    end
    check("b2b_stalls", 128'(tot), 0);
    check("fill_outstanding_after_w", outstanding, 4);
    check("fill_awready_before_b", axi.s_awready, 0);
    bready_man = 1'b1;
    @(posedge clk); #1;
    check("awready_after_first_b", axi.s_awready, 1);
    check("outstanding_after_first_b", outstanding, 3);
    wait_drain();

    // Reset in the middle of a long burst.
    t = mk(4'd6, 32'h200, 8'd7, 3'd3, 2'b01, -1);
    exp_q.push_back({32'h200, beat_data(t.seed, 0), beat_strb(t.seed, 0)});
    exp_q.push_back({32'h208, beat_data(t.seed, 1), beat_strb(t.seed, 1)});
    aw_send(t);
    for (int k = 0; k < 2; k++) begin
      axi.s_wvalid = 1'b1; axi.s_wdata = beat_data(t.seed, k);
      axi.s_wstrb = beat_strb(t.seed, k); axi.s_wlast = 1'b0;
      @(posedge clk); #1;
    end
    axi.s_wdata = beat_data(t.seed, 2); axi.s_wstrb = beat_strb(t.seed, 2);
    #5;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_wready", axi.s_wready, 0);
    check("midrst_bvalid", axi.s_bvalid, 0);
    check("midrst_outstanding", outstanding, 0);
    check("midrst_mem_we", mem_we, 0);
    check("midrst_partial_writes", 128'(exp_q.size()), 0);
    axi.s_wvalid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    t = mk(4'd2, 32'h500, 8'd1, 3'd3, 2'b01, -1);
    wr0 = wr_count;
    push_model(t);
    aw_send(t);
    w_send(t, st);
    wait_drain();
    check("post_rst_nwrites", 128'(wr_count - wr0), 2);
    check("post_rst_bid", last_bid, 2);
    check("post_rst_bresp", last_bresp, 0);

    // Random traffic with random gaps and back-pressure.
    rand_bready = 1'b1;
    rand_gaps = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] len;
      int wl;
      len = 8'($urandom_range(0, 7));
      wl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, int'(len) + 1)) : -1;
      t = mk(4'($urandom), $urandom, len, 3'($urandom_range(0, 4)),
             ($urandom_range(0, 5) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1)), wl);
      push_model(t);
      aw_send(t);
      w_send(t, st);
    end
    rand_bready = 1'b0;
    rand_gaps = 1'b0;
    bready_man = 1'b1;
    wait_drain();
    repeat (2) @(posedge clk);
    #1;
    check("final_outstanding", outstanding, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
